// File: rtl/sdram_port_arbiter.sv
// Two-client arbiter for the SDRAM controller command port: round-robin write/read
// grants with a per-grant burst limit, outstanding-read tracking and init gating.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned BURST_LEN     = 8,
    parameter int unsigned MAX_RD_OUTSTD = 4
) (
    input  logic              sdram_clk,
    input  logic              rst,
    input  logic              sdram_init_done,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] cmd_rdata,
    input  logic              cmd_rdata_valid,
    output logic              grant_wr,
    output logic              grant_rd,
    output logic              rd_underflow
);
    localparam int unsigned BCNT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned OCNT_W = $clog2(MAX_RD_OUTSTD + 1);
    localparam logic [BCNT_W-1:0] BEAT_LAST  = BCNT_W'(BURST_LEN - 1);
    localparam logic [OCNT_W-1:0] OUTSTD_MAX = OCNT_W'(MAX_RD_OUTSTD);

    typedef enum logic [1:0] {IDLE, GNT_WR, GNT_RD} state_t;
    typedef enum logic {SIDE_WR, SIDE_RD} side_t;

    state_t             state_q, state_d;
    side_t              last_grant_q, last_grant_d;
    logic [BCNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [OCNT_W-1:0]  rd_outstd_q, rd_outstd_d;
    logic               rd_underflow_q, rd_underflow_d;

    logic wq, rq, own_q, other_q, beat_acc, rd_acc, burst_end, enter;
    state_t other_state;

    always_comb begin
        wq = wr_valid & sdram_init_done;
        rq = rd_valid & sdram_init_done & (rd_outstd_q < OUTSTD_MAX);

        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        wr_ready  = 1'b0;
        rd_ready  = 1'b0;
        unique case (state_q)
            GNT_WR: begin
                cmd_valid = wq;
                cmd_we    = 1'b1;
                cmd_addr  = wr_addr;
                cmd_wdata = wr_data;
                wr_ready  = cmd_ready & sdram_init_done;
            end
            GNT_RD: begin
                cmd_valid = rq;
                cmd_addr  = rd_addr;
                rd_ready  = cmd_ready & rq;
            end
            default: ;
        endcase
    end

    always_comb begin
        beat_acc    = cmd_valid & cmd_ready;
        rd_acc      = beat_acc & (state_q == GNT_RD);
        burst_end   = beat_acc & (beat_cnt_q == BEAT_LAST);
        own_q       = (state_q == GNT_WR) ? wq : rq;
        other_q     = (state_q == GNT_WR) ? rq : wq;
        other_state = (state_q == GNT_WR) ? GNT_RD : GNT_WR;

        state_d      = state_q;
        enter        = 1'b0;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;

        if (state_q == IDLE) begin
            if (wq && (!rq || last_grant_q == SIDE_RD)) begin
                state_d = GNT_WR;
                enter   = 1'b1;
            end else if (rq) begin
                state_d = GNT_RD;
                enter   = 1'b1;
            end
        end else if (!sdram_init_done) begin
            state_d = IDLE;
        end else if (burst_end || !own_q) begin
            // own_q still high here means the burst limit caused the release
            if (other_q) begin
                state_d = other_state;
                enter   = 1'b1;
            end else if (own_q) begin
                enter   = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        if (enter) begin
            beat_cnt_d   = '0;
            last_grant_d = (state_d == GNT_WR) ? SIDE_WR : SIDE_RD;
        end else if (beat_acc) begin
            beat_cnt_d = beat_cnt_q + BCNT_W'(1);
        end

        rd_outstd_d    = rd_outstd_q;
        rd_underflow_d = rd_underflow_q;
        if (rd_acc && !cmd_rdata_valid) begin
            rd_outstd_d = rd_outstd_q + OCNT_W'(1);
        end else if (!rd_acc && cmd_rdata_valid) begin
            if (rd_outstd_q == '0) begin
                rd_underflow_d = 1'b1;
            end else begin
                rd_outstd_d = rd_outstd_q - OCNT_W'(1);
            end
        end
    end

    always_ff @(posedge sdram_clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= SIDE_RD;
            beat_cnt_q     <= '0;
            rd_outstd_q    <= '0;
            rd_underflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            beat_cnt_q     <= beat_cnt_d;
            rd_outstd_q    <= rd_outstd_d;
            rd_underflow_q <= rd_underflow_d;
        end
    end

    assign grant_wr      = (state_q == GNT_WR);
    assign grant_rd      = (state_q == GNT_RD);
    assign rd_underflow  = rd_underflow_q;
    assign rd_data       = cmd_rdata;
    assign rd_data_valid = cmd_rdata_valid;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: expected commands and read returns are
// queued when driven and checked when the arbiter issues or routes them.
module tb_sdram_port_arbiter;
    localparam logic [31:0] WA_BASE = 32'h0000_1000;
    localparam logic [31:0] RA_BASE = 32'h0008_0000;

    logic        sdram_clk = 1'b0;
    logic        rst = 1'b1;
    logic        sdram_init_done = 1'b0;
    logic        wr_valid = 1'b0, rd_valid = 1'b0;
    logic        wr_ready, rd_ready;
    logic [31:0] wr_addr = '0, rd_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        rd_data_valid;
    logic        cmd_valid, cmd_we;
    logic        cmd_ready = 1'b0;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [15:0] cmd_rdata = '0;
    logic        cmd_rdata_valid = 1'b0;
    logic        grant_wr, grant_rd, rd_underflow;

    int unsigned n_assert = 0, n_fail = 0;
    int unsigned cyc_n = 0;
    int unsigned wr_idx = 0, wr_pushed = 0, rd_idx = 0, rd_pushed = 0;
    logic        auto_ret = 1'b0, ret_now = 1'b0;
    logic [47:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [15:0] inflight[$];
    int unsigned due_q[$];
    int unsigned base;

    sdram_port_arbiter #(.ADDR_W(32), .DATA_W(16), .BURST_LEN(8), .MAX_RD_OUTSTD(4)) dut (
        .sdram_clk(sdram_clk), .rst(rst), .sdram_init_done(sdram_init_done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_rdata(cmd_rdata), .cmd_rdata_valid(cmd_rdata_valid),
        .grant_wr(grant_wr), .grant_rd(grant_rd), .rd_underflow(rd_underflow)
    );

    always #5 sdram_clk = ~sdram_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive this cycle's addresses/returns, then check outputs of the same cycle.
    task automatic drive_and_check(input int egw, input int egr, input int eacc);
        logic        acc, do_ret;
        logic [47:0] ew;
        logic [31:0] er;
        wr_addr = WA_BASE + wr_idx;
        wr_data = 16'hC000 ^ 16'(wr_idx);
        if (wr_valid && wr_pushed == wr_idx) begin
            exp_wr.push_back({wr_addr, wr_data});
            wr_pushed++;
        end
        rd_addr = RA_BASE + (rd_idx << 2);
        if (rd_valid && rd_pushed == rd_idx) begin
            exp_rd.push_back(rd_addr);
            rd_pushed++;
        end
        do_ret = ret_now;
        if (auto_ret && due_q.size() > 0 && due_q[0] == cyc_n) begin
            void'(due_q.pop_front());
            do_ret = 1'b1;
        end
        cmd_rdata_valid = do_ret;
        if (do_ret) cmd_rdata = (inflight.size() > 0) ? inflight.pop_front() : 16'hDEAD;
        #1;
        acc = cmd_valid & cmd_ready;
        if (egw >= 0) chk("grant_wr", grant_wr, 64'(egw));
        if (egr >= 0) chk("grant_rd", grant_rd, 64'(egr));
        if (eacc >= 0) chk("beat_accept", acc, 64'(eacc));
        if (egw == 0 && egr == 0) begin
            chk("idle_cmd_valid", cmd_valid, 0);
            chk("idle_cmd_addr", cmd_addr, 0);
            chk("idle_cmd_we", cmd_we, 0);
            chk("idle_wr_ready", wr_ready, 0);
            chk("idle_rd_ready", rd_ready, 0);
        end
        if (egw == 1) begin
            chk("wr_ready", wr_ready, 64'(cmd_ready & sdram_init_done));
            chk("rd_ready_not_granted", rd_ready, 0);
        end
        if (egr == 1) begin
            if (eacc >= 0) chk("rd_ready", rd_ready, 64'(eacc));
            chk("wr_ready_not_granted", wr_ready, 0);
        end
        if (acc && egw == 1) begin
            ew = (exp_wr.size() > 0) ? exp_wr.pop_front() : 'x;
            chk("wr_cmd_we", cmd_we, 1);
            chk("wr_cmd_addr_data", {cmd_addr, cmd_wdata}, 64'(ew));
            wr_idx++;
        end
        if (acc && egr == 1) begin
            er = (exp_rd.size() > 0) ? exp_rd.pop_front() : 'x;
            chk("rd_cmd_we", cmd_we, 0);
            chk("rd_cmd_addr", cmd_addr, 64'(er));
            chk("rd_cmd_wdata", cmd_wdata, 0);
            inflight.push_back(er[15:0] ^ 16'h5A5A);
            if (auto_ret) due_q.push_back(cyc_n + 3);
            rd_idx++;
        end
        chk("rd_data_valid", rd_data_valid, 64'(do_ret));
        if (do_ret) chk("rd_data", rd_data, 64'(cmd_rdata));
    endtask

    task automatic advance();
        @(posedge sdram_clk);
        #1;
        cyc_n++;
    endtask

    task automatic step(input int egw, input int egr, input int eacc);
        drive_and_check(egw, egr, eacc);
        advance();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge sdram_clk);
        #1;
        chk("rst_grant_wr", grant_wr, 0);
        chk("rst_grant_rd", grant_rd, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_underflow", rd_underflow, 0);
        chk("rst_wr_ready", wr_ready, 0);
        rst = 1'b0;

        // Write only: one idle cycle, then 20 back-to-back beats across re-grants
        sdram_init_done = 1'b1; wr_valid = 1'b1; cmd_ready = 1'b1;
        base = wr_idx;
        step(0, 0, 0);
        for (int k = 0; k < 20; k++) step(1, 0, 1);
        chk("wr_only_beats", wr_idx - base, 20);
        wr_valid = 1'b0;
        step(1, 0, 0);
        step(0, 0, 0);

        // Contention from reset: WR(8) RD(8) WR(8) RD(8), return latency 3
        rst = 1'b1; #1; rst = 1'b0;
        auto_ret = 1'b1;
        wr_valid = 1'b1; rd_valid = 1'b1;
        step(0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) step(1, 0, 1);
            for (int k = 0; k < 8; k++) step(0, 1, 1);
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        for (int k = 0; k < 10 && due_q.size() > 0; k++) step(-1, -1, 0);
        step(-1, -1, 0);
        chk("contention_returns_drained", inflight.size(), 0);
        chk("contention_no_underflow", rd_underflow, 0);
        auto_ret = 1'b0;

        // Outstanding limit with returns withheld
        rd_valid = 1'b1;
        step(0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 1);
        step(0, 1, 0);
        ret_now = 1'b1; step(0, 0, 0);
        ret_now = 1'b0; step(0, 0, 0);
        ret_now = 1'b1; step(0, 1, 1);
        ret_now = 1'b0; step(0, 1, 1);
        step(0, 1, 0);
        rd_valid = 1'b0;
        ret_now = 1'b1;
        for (int k = 0; k < 4; k++) step(0, 0, 0);
        ret_now = 1'b0;
        step(0, 0, 0);
        chk("outstd_no_underflow", rd_underflow, 0);
        chk("outstd_returns_drained", inflight.size(), 0);

        // Backpressure: 8 accepted beats over 15 cycles, then the read side
        wr_valid = 1'b1; rd_valid = 1'b1;
        step(0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            cmd_ready = (k % 2 == 0);
            if (k < 15) step(1, 0, int'(cmd_ready));
            else        step(0, 1, 0);
        end
        wr_valid = 1'b0; rd_valid = 1'b0; cmd_ready = 1'b1;
        step(0, 1, 0);
        step(0, 0, 0);

        // Init gating
        sdram_init_done = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1;
        for (int k = 0; k < 3; k++) step(0, 0, 0);
        sdram_init_done = 1'b1;
        step(0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 1);
        sdram_init_done = 1'b0;
        step(1, 0, 0);
        step(0, 0, 0);
        wr_valid = 1'b0; rd_valid = 1'b0; sdram_init_done = 1'b1;
        step(0, 0, 0);

        // Underflow is sticky; async reset mid-burst clears everything
        ret_now = 1'b1; step(0, 0, 0);
        ret_now = 1'b0;
        chk("underflow_set", rd_underflow, 1);
        step(0, 0, 0);
        chk("underflow_sticky", rd_underflow, 1);
        wr_valid = 1'b1;
        step(0, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_grant_wr", grant_wr, 0);
        chk("async_rst_cmd_valid", cmd_valid, 0);
        chk("async_rst_wr_ready", wr_ready, 0);
        chk("async_rst_cmd_addr", cmd_addr, 0);
        chk("async_rst_underflow", rd_underflow, 0);
        rst = 1'b0; wr_valid = 1'b0;
        advance();
        step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
